// File: rtl/softmax_pkg.sv
// softmax_pkg: shared lane geometry, FSM state type and lane-slice helpers for the softmax arbiter
package softmax_pkg;
    localparam int LANES = 4;
    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int REQ_W = LANES * IN_W;
    localparam int RSP_W = LANES * OUT_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    function automatic logic [IN_W-1:0] in_lane(input logic [REQ_W-1:0] v, input int k);
        return v[k*IN_W +: IN_W];
    endfunction

    function automatic logic [OUT_W-1:0] out_lane(input logic [RSP_W-1:0] v, input int k);
        return v[k*OUT_W +: OUT_W];
    endfunction
endpackage

// File: rtl/softmax_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick over NREQ requesters
//   req_i  - request levels
//   ptr_i  - highest-priority index for this pick
//   gnt_o  - one-hot winner (all zero when no request)
//   idx_o  - winner index
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o
);
    logic [PW-1:0] j;

    // Walk from the farthest offset down to ptr itself so the nearest set bit wins last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = PW'((int'(ptr_i) + i) % NREQ);
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end
endmodule

// File: rtl/softmax_arbiter.sv
// softmax_arbiter: round-robin sharing of one 4-lane softmax engine between NREQ requesters
//   clk, reset_n        - clock, asynchronous active-low reset
//   req, req_data       - request levels and per-requester 64-bit logits
//   gnt                 - one-hot acceptance pulse
//   rsp_valid, rsp_data - one-hot response strobe and 32-bit probabilities
//   rsp_err             - response aborted by the watchdog
//   busy                - transaction in flight
//   eng_start, eng_in   - engine start pulse and held operands
//   eng_done, eng_out   - engine completion pulse and results
// Optional watchdog enabled by defining SOFTMAX_ARB_TIMEOUT_EN.
module softmax_arbiter
    import softmax_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*REQ_W-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [RSP_W-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  eng_start,
    output logic [REQ_W-1:0]      eng_in,
    input  logic                  eng_done,
    input  logic [RSP_W-1:0]      eng_out
);
    localparam int PW = $clog2(NREQ);

    state_e           state_q;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d, win_idx;
    logic [NREQ-1:0]  owner_q, gnt_q, rsp_valid_q, win_gnt;
    logic [RSP_W-1:0] rsp_data_q;
    logic [REQ_W-1:0] eng_in_q;
    logic             busy_q, eng_start_q;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx)
    );

    assign rr_ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef SOFTMAX_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;
    logic [CW-1:0] tmo_q;
    logic          rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // owner_q is kept one-hot so it can be copied straight onto rsp_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            eng_in_q    <= '0;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
`ifdef SOFTMAX_ARB_TIMEOUT_EN
            tmo_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            gnt_q       <= '0;
            eng_start_q <= 1'b0;
            case (state_q)
                IDLE: if (|req) begin
                    gnt_q       <= win_gnt;
                    owner_q     <= win_gnt;
                    eng_in_q    <= req_data[win_idx*REQ_W +: REQ_W];
                    eng_start_q <= 1'b1;
                    busy_q      <= 1'b1;
                    rr_ptr_q    <= rr_ptr_d;
                    state_q     <= WAIT;
`ifdef SOFTMAX_ARB_TIMEOUT_EN
                    tmo_q       <= '0;
`endif
                end
                WAIT: if (eng_done) begin
                    rsp_data_q  <= eng_out;
                    rsp_valid_q <= owner_q;
                    state_q     <= RESP;
`ifdef SOFTMAX_ARB_TIMEOUT_EN
                    rsp_err_q   <= 1'b0;
                end else if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_q  <= '0;
                    rsp_valid_q <= owner_q;
                    rsp_err_q   <= 1'b1;
                    state_q     <= RESP;
                end else begin
                    tmo_q       <= tmo_q + 1'b1;
`endif
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
`ifdef SOFTMAX_ARB_TIMEOUT_EN
                    rsp_err_q   <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign eng_start = eng_start_q;
    assign eng_in    = eng_in_q;
endmodule

// File: doc/softmax_arbiter.md
Name: softmax_arbiter

Overview:
- Shares one 4-lane softmax engine (16-bit logits in, 8-bit probabilities out, start/done handshake) between NREQ requesters, e.g. per-head attention units.
- Round-robin grant; latches the winner's operands and pulses the engine start.
- Holds operands stable until the engine reports done, then returns the result to the owner with a one-cycle response strobe.
- Sits between the requesters and the engine instance in the accelerator datapath.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level; held with req_data until gnt.
- req_data  in  NREQ*64  per-requester logits; lane k of requester i at [i*64+k*16 +: 16].
- gnt  out  NREQ  one-hot, one-cycle pulse when the request is accepted.
- rsp_valid  out  NREQ  one-hot, one-cycle pulse when rsp_data is valid for that requester.
- rsp_data  out  32  probabilities; lane k at [k*8 +: 8].
- rsp_err  out  1  qualifies rsp_valid; 1 = aborted by the watchdog.
- busy  out  1  high from the grant edge until the RESP state exits.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_in  out  64  latched operands to the engine; lane k at [k*16 +: 16].
- eng_done  in  1  engine completion pulse; eng_out is valid while it is high.
- eng_out  in  32  engine results; lane k at [k*8 +: 8].

Behaviour:
- All outputs are registered. On reset_n low: state=IDLE, rr_ptr=0; gnt, rsp_valid, rsp_err, eng_start, busy, rsp_data, eng_in all 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE, any req high:
  - Winner = first set bit searching upward from rr_ptr, wrapping at NREQ-1.
  - At that edge: gnt[winner]<=1, eng_in<=winner's req_data, owner<=winner, eng_start<=1, busy<=1, rr_ptr<=(winner+1) mod NREQ, state<=WAIT.
  - gnt and eng_start clear on the next edge.
- IDLE, no req: stay in IDLE; rr_ptr unchanged.
- WAIT, eng_done high: rsp_data<=eng_out, rsp_valid[owner]<=1, rsp_err<=0, state<=RESP.
- RESP: next edge clears rsp_valid and rsp_err, busy<=0, state<=IDLE. There is no back-to-back grant in the RESP cycle, so the minimum issue interval is engine latency + 2 cycles.
- eng_in is held constant from the grant edge until the next grant; it never changes mid-transaction.
- The current engine asserts eng_done 4 cycles after the eng_start edge. The arbiter does not depend on that figure.
- eng_done arriving in IDLE or RESP is ignored (stray pulse). eng_done coinciding with the grant edge is ignored.
- Requests arriving while busy stay pending; req is level-sensitive and must remain asserted until gnt.
- A req dropped before gnt is simply not granted; there is no error.
- Simultaneous requests: the round-robin order guarantees each requester a grant within NREQ transactions.
- Reset mid-transaction: the arbiter returns to IDLE immediately and no response is produced for the in-flight owner. The system resets the engine in the same event.

Optional Feature:
- Macro SOFTMAX_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on the grant edge and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without eng_done: rsp_valid[owner]<=1, rsp_err<=1, rsp_data<=0, state<=RESP.
  - A later stray eng_done is ignored.
- Not defined: WAIT lasts indefinitely, rsp_err is tied 0, and no counter logic exists.

Decomposition:
- Package softmax_pkg holds:
  - Constants: LANES=4, IN_W=16, OUT_W=8.
  - The FSM state typedef: IDLE, WAIT, RESP.
  - Lane-slice helper functions.
- One sub-module, rr_arbiter: a combinational NREQ-wide round-robin pick that takes req and rr_ptr and returns a one-hot grant plus the winner index. The FSM and datapath registers stay in softmax_arbiter.

Test Plan:
- Single request. req=01, logits {0,0,0,0}. Expect gnt[0] one cycle later, eng_start one cycle, eng_in=0, and rsp_valid[0] one cycle after eng_done with rsp_data = engine output, busy low afterward.
- Contention. req=11 held continuously from reset. Expect grants in order 0,1,0,1, each rsp_valid routed to the matching owner, and no grant while busy.
- Pointer wrap, NREQ=4. Grant 3 first, then req=1001. Expect the next grant to go to 0 (wrap), then 3.
- Stray done. Pulse eng_done in IDLE. Expect no rsp_valid and no state change. A following request completes normally.
- Reset mid-WAIT. Assert reset_n low 2 cycles after the grant. Expect all outputs 0, no rsp_valid, and the next request granted from rr_ptr=0.
- Timeout (SOFTMAX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8). Engine never asserts done. Expect rsp_valid with rsp_err=1 and rsp_data=0 eight WAIT cycles after the grant; a late eng_done is ignored.
